// File: rtl/alu_wb_stage_if.sv
// Signal bundle between the ALU result producer / register-file write port
// and the writeback stage. The stage itself connects through the slave view.
interface alu_wb_stage_if #(
    parameter int WORD_W = 20,
    parameter int ADDR_W = 4
);
    // ALU packet side
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic              in_mode;
    logic [ADDR_W-1:0] in_dst_a;
    logic [ADDR_W-1:0] in_dst_b;
    logic [WORD_W-1:0] in_res_a;
    logic [WORD_W-1:0] in_res_b;
    logic              in_zero;
    logic              in_sign;
    logic              in_carry;

    // register-file write side
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    // status towards the jump-condition logic
    logic [2:0]        status;
    logic              busy;

    // Environment view: produces packets and plays the register file.
    modport master (
        output in_valid, in_op, in_mode, in_dst_a, in_dst_b,
               in_res_a, in_res_b, in_zero, in_sign, in_carry,
        input  in_ready,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  status, busy
    );

    // Writeback stage view.
    modport slave (
        input  in_valid, in_op, in_mode, in_dst_a, in_dst_b,
               in_res_a, in_res_b, in_zero, in_sign, in_carry,
        output in_ready,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output status, busy
    );
endinterface

// File: rtl/alu_wb_stage.sv
// Writeback stage behind the ALU: 2-entry packet buffer, register-file write
// beats (two for a swap) and the {Z,S,C} status register.
module alu_wb_stage #(
    parameter int WORD_W = 20,
    parameter int HALF_W = 10,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_wb_stage_if.slave bus
);

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_SWAP  = 3'd1;
    localparam logic [2:0] OP_LDSR  = 3'd3;
    localparam logic [2:0] OP_XORSR = 3'd4;

    localparam logic [0:0] BEAT0 = 1'b0;
    localparam logic [0:0] BEAT1 = 1'b1;

    typedef struct packed {
        logic [2:0]        op;
        logic              mode;
        logic [ADDR_W-1:0] dst_a;
        logic [ADDR_W-1:0] dst_b;
        logic [WORD_W-1:0] res_a;
        logic [WORD_W-1:0] res_b;
        logic              zero;
        logic              sign;
        logic              carry;
    } pkt_t;

    // state
    pkt_t              fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [0:0]        state;
    logic [2:0]        status_q;
    logic [ADDR_W-1:0] hold_addr;
    logic [WORD_W-1:0] hold_data;

    // combinational
    pkt_t              in_pkt;
    pkt_t              head;
    logic              head_valid;
    logic              head_is_beat;
    logic              can_push;
    logic              push;
    logic              beat_hs;
    logic              retire;
    logic              beat_sign;
    logic [ADDR_W-1:0] beat_addr;
    logic [WORD_W-1:0] beat_data;
    logic [2:0]        status_next;

    // Capture the incoming packet, flags included, as one buffer entry.
    always_comb begin
        in_pkt.op    = bus.in_op;
        in_pkt.mode  = bus.in_mode;
        in_pkt.dst_a = bus.in_dst_a;
        in_pkt.dst_b = bus.in_dst_b;
        in_pkt.res_a = bus.in_res_a;
        in_pkt.res_b = bus.in_res_b;
        in_pkt.zero  = bus.in_zero;
        in_pkt.sign  = bus.in_sign;
        in_pkt.carry = bus.in_carry;
    end

    // Decode the head entry, form the current beat and decide push/retire.
    always_comb begin
        // NOTE: each signal is given a value before any branch so no path leaves it unassigned (no latch).
        head         = fifo_mem[rd_ptr];
        head_valid   = (count != 2'd0);
        head_is_beat = head_valid && ((head.op == OP_WRITE) || (head.op == OP_SWAP));
        beat_addr    = head.dst_a;
        beat_data    = head.res_a;
        if (state == BEAT1) begin
            beat_addr = head.dst_b;
            beat_data = head.res_b;
        end
        // Half-word results never carry upper bits into the register file.
        if (!head.mode) begin
            beat_data[WORD_W-1:HALF_W] = '0;
        end

        // Acceptance looks at the registered count only: a full buffer
        // refuses a packet even when the head retires in the same cycle.
        can_push = (count < 2'd2);
        push     = bus.in_valid && can_push;
        beat_hs  = head_is_beat && bus.wr_ready;
        retire   = (head_valid && !head_is_beat)
                || (beat_hs && ((head.op == OP_WRITE) || (state == BEAT1)));
    end

    // Status value the head packet commits when it retires.
    always_comb begin
        beat_sign = head.mode ? head.res_a[WORD_W-1] : head.res_a[HALF_W-1];
        case (head.op)
            OP_WRITE, OP_SWAP: status_next = {head.zero, beat_sign, head.carry};
            OP_LDSR:           status_next = head.res_a[2:0];
            OP_XORSR:          status_next = status_q ^ head.res_a[2:0];
            default:           status_next = {head.zero, head.sign, head.carry};
        endcase
    end

    // Packet storage, written on push only.
    // NOTE: the entries have no reset; count guarantees an entry is never consumed before it is written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_pkt;
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values.
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (retire) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, retire};
        end
    end

    // Beat FSM: a swap moves to its second beat after the first handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BEAT0;
        end else if (beat_hs) begin
            state <= ((state == BEAT0) && (head.op == OP_SWAP)) ? BEAT1 : BEAT0;
        end
    end

    // Status register, committed only when a packet retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 3'b000;
        end else if (retire) begin
            status_q <= status_next;
        end
    end

    // Last accepted beat, so the write port holds its values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (beat_hs) begin
            hold_addr <= beat_addr;
            hold_data <= beat_data;
        end
    end

    assign bus.in_ready = can_push;
    assign bus.wr_valid = head_is_beat;
    assign bus.wr_addr  = head_is_beat ? beat_addr : hold_addr;
    assign bus.wr_data  = head_is_beat ? beat_data : hold_data;
    assign bus.status   = status_q;
    assign bus.busy     = head_valid;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus a randomized
// run against a packet-queue reference model.
module tb_alu_wb_stage;

    localparam int WORD_W = 20;
    localparam int HALF_W = 10;
    localparam int ADDR_W = 4;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_SWAP  = 3'd1;
    localparam logic [2:0] OP_FLAGS = 3'd2;
    localparam logic [2:0] OP_LDSR  = 3'd3;
    localparam logic [2:0] OP_XORSR = 3'd4;

    typedef struct {
        logic [2:0]  op;
        logic        mode;
        logic [3:0]  da;
        logic [3:0]  db;
        logic [19:0] ra;
        logic [19:0] rb;
        logic        z;
        logic        s;
        logic        c;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_wb_stage_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    alu_wb_stage #(
        .WORD_W(WORD_W),
        .HALF_W(HALF_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_pkt(input logic vld, input pkt_t p);
        bus.in_valid = vld;
        bus.in_op    = p.op;
        bus.in_mode  = p.mode;
        bus.in_dst_a = p.da;
        bus.in_dst_b = p.db;
        bus.in_res_a = p.ra;
        bus.in_res_b = p.rb;
        bus.in_zero  = p.z;
        bus.in_sign  = p.s;
        bus.in_carry = p.c;
    endtask

    function automatic pkt_t mk(input logic [2:0] op, input logic mode,
                                input logic [3:0] da, input logic [3:0] db,
                                input logic [19:0] ra, input logic [19:0] rb,
                                input logic z, input logic s, input logic c);
        pkt_t p;
        p.op = op; p.mode = mode; p.da = da; p.db = db;
        p.ra = ra; p.rb = rb; p.z = z; p.s = s; p.c = c;
        return p;
    endfunction

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        drive_pkt(1'b0, mk(3'd0, 1'b0, 4'd0, 4'd0, 20'd0, 20'd0, 1'b0, 1'b0, 1'b0));
        bus.wr_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- reference model helpers ----------------
    function automatic logic [19:0] visible_data(input logic mode, input logic [19:0] d);
        return mode ? d : (d % 20'd1024);
    endfunction

    function automatic logic [2:0] apply_op(input logic [2:0] st, input pkt_t p);
        logic [19:0] sh;
        sh = p.ra >> (p.mode ? 19 : 9);
        case (p.op)
            OP_WRITE, OP_SWAP: return {p.z, sh[0], p.c};
            OP_LDSR:           return p.ra[2:0];
            OP_XORSR:          return st ^ p.ra[2:0];
            default:           return {p.z, p.s, p.c};
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.wr_ready = 1'b0;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %0b want 0", bus.wr_valid); end
        n_checks++; if (bus.wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0h want 0", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 20'd0) begin n_fail++; $display("FAIL reset_wr_data: got %0h want 0", bus.wr_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_checks++; if (bus.status !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %03b want 000", bus.status); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_full();
        bus.wr_ready = 1'b1;
        drive_pkt(1'b1, mk(OP_WRITE, 1'b1, 4'd3, 4'd9, 20'hABCDE, 20'h11111, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        idle();
        n_checks++; if (bus.wr_valid !== 1'b1) begin n_fail++; $display("FAIL wfull_valid: got %0b want 1", bus.wr_valid); end
        n_checks++; if (bus.wr_addr !== 4'd3) begin n_fail++; $display("FAIL wfull_addr: got %0h want 3", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 20'hABCDE) begin n_fail++; $display("FAIL wfull_data: got %0h want abcde", bus.wr_data); end
        n_checks++; if (bus.status !== 3'b000) begin n_fail++; $display("FAIL wfull_status_early: got %03b want 000", bus.status); end
        @(negedge clk);
        n_checks++; if (bus.status !== 3'b011) begin n_fail++; $display("FAIL wfull_status: got %03b want 011", bus.status); end
        n_checks++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL wfull_single_beat: got %0b want 0", bus.wr_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wfull_busy: got %0b want 0", bus.busy); end
        n_checks++; if (bus.wr_data !== 20'hABCDE) begin n_fail++; $display("FAIL wfull_hold_data: got %0h want abcde", bus.wr_data); end
    endtask

    task automatic test_write_half();
        bus.wr_ready = 1'b1;
        drive_pkt(1'b1, mk(OP_WRITE, 1'b0, 4'd5, 4'd0, 20'hFF3FF, 20'h0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        idle();
        n_checks++; if (bus.wr_addr !== 4'd5) begin n_fail++; $display("FAIL whalf_addr: got %0h want 5", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 20'h003FF) begin n_fail++; $display("FAIL whalf_data: got %0h want 003ff", bus.wr_data); end
        n_checks++; if (bus.status !== 3'b011) begin n_fail++; $display("FAIL whalf_status_early: got %03b want 011", bus.status); end
        @(negedge clk);
        n_checks++; if (bus.status !== 3'b110) begin n_fail++; $display("FAIL whalf_status: got %03b want 110", bus.status); end
    endtask

    task automatic test_swap();
        bus.wr_ready = 1'b1;
        drive_pkt(1'b1, mk(OP_SWAP, 1'b1, 4'd1, 4'd2, 20'd5, 20'd7, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        idle();
        n_checks++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 4'd1 || bus.wr_data !== 20'd5) begin
            n_fail++; $display("FAIL swap_beat0: got v=%0b a=%0h d=%0h want v=1 a=1 d=5", bus.wr_valid, bus.wr_addr, bus.wr_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL swap_in_ready: got %0b want 1", bus.in_ready); end
        @(negedge clk);
        n_checks++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 4'd2 || bus.wr_data !== 20'd7) begin
            n_fail++; $display("FAIL swap_beat1: got v=%0b a=%0h d=%0h want v=1 a=2 d=7", bus.wr_valid, bus.wr_addr, bus.wr_data); end
        n_checks++; if (bus.busy !== 1'b1 || bus.status !== 3'b110) begin
            n_fail++; $display("FAIL swap_mid: got busy=%0b st=%03b want busy=1 st=110", bus.busy, bus.status); end
        @(negedge clk);
        n_checks++; if (bus.wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL swap_done: got v=%0b busy=%0b want 0 0", bus.wr_valid, bus.busy); end
        n_checks++; if (bus.status !== 3'b001) begin n_fail++; $display("FAIL swap_status: got %03b want 001", bus.status); end
    endtask

    task automatic test_status_ops();
        pkt_t seq [4];
        logic [2:0] want [5];
        seq[0] = mk(OP_LDSR,  1'b1, 4'd0, 4'd0, 20'h00005, 20'h0, 1'b0, 1'b0, 1'b0);
        seq[1] = mk(OP_XORSR, 1'b1, 4'd0, 4'd0, 20'hFFFF7, 20'h0, 1'b0, 1'b0, 1'b0);
        seq[2] = mk(OP_FLAGS, 1'b1, 4'd0, 4'd0, 20'h00000, 20'h0, 1'b1, 1'b1, 1'b0);
        seq[3] = mk(3'd7,     1'b0, 4'd0, 4'd0, 20'h00007, 20'h0, 1'b0, 1'b1, 1'b1);
        want[0] = 3'b001; want[1] = 3'b101; want[2] = 3'b010; want[3] = 3'b110; want[4] = 3'b011;
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_pkt(1'b1, seq[i]); else idle();
            @(negedge clk);
            n_checks++; if (bus.status !== want[i]) begin n_fail++; $display("FAIL sr_status_%0d: got %03b want %03b", i, bus.status, want[i]); end
            n_checks++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL sr_no_beat_%0d: got %0b want 0", i, bus.wr_valid); end
        end
        idle();
        @(negedge clk);
        n_checks++; if (bus.status !== 3'b011 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL sr_final: got st=%03b busy=%0b want 011 0", bus.status, bus.busy); end
    endtask

    task automatic test_backpressure();
        pkt_t a, b, c;
        a = mk(OP_WRITE, 1'b1, 4'd4, 4'd0, 20'h11111, 20'h0, 1'b0, 1'b0, 1'b1);
        b = mk(OP_WRITE, 1'b1, 4'd5, 4'd0, 20'h22222, 20'h0, 1'b1, 1'b0, 1'b0);
        c = mk(OP_WRITE, 1'b1, 4'd6, 4'd0, 20'h33333, 20'h0, 1'b1, 1'b1, 1'b1);
        bus.wr_ready = 1'b0;
        drive_pkt(1'b1, a);
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %0b want 1", bus.in_ready); end
        drive_pkt(1'b1, b);
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %0b want 0", bus.in_ready); end
        drive_pkt(1'b1, c);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_blocked_%0d: got %0b want 0", i, bus.in_ready); end
            n_checks++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 4'd4 || bus.wr_data !== 20'h11111) begin
                n_fail++; $display("FAIL bp_stable_%0d: got v=%0b a=%0h d=%0h want 1 4 11111", i, bus.wr_valid, bus.wr_addr, bus.wr_data); end
            n_checks++; if (bus.status !== 3'b011) begin n_fail++; $display("FAIL bp_status_hold_%0d: got %03b want 011", i, bus.status); end
        end
        idle();
        bus.wr_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 4'd5 || bus.wr_data !== 20'h22222) begin
            n_fail++; $display("FAIL bp_second_beat: got v=%0b a=%0h d=%0h want 1 5 22222", bus.wr_valid, bus.wr_addr, bus.wr_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0b want 1", bus.in_ready); end
        n_checks++; if (bus.status !== 3'b001) begin n_fail++; $display("FAIL bp_status_a: got %03b want 001", bus.status); end
        @(negedge clk);
        n_checks++; if (bus.wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_drained: got v=%0b busy=%0b want 0 0", bus.wr_valid, bus.busy); end
        n_checks++; if (bus.status !== 3'b100) begin n_fail++; $display("FAIL bp_status_b: got %03b want 100", bus.status); end
        @(negedge clk);
        n_checks++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_third_absent: got %0b want 0", bus.wr_valid); end
    endtask

    task automatic test_reset_mid_swap();
        bus.wr_ready = 1'b1;
        drive_pkt(1'b1, mk(OP_SWAP, 1'b1, 4'd7, 4'd8, 20'h12345, 20'h54321, 1'b1, 1'b1, 1'b1));
        @(negedge clk);
        idle();
        n_checks++; if (bus.wr_addr !== 4'd7) begin n_fail++; $display("FAIL rs_beat0: got %0h want 7", bus.wr_addr); end
        @(negedge clk);
        n_checks++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 4'd8) begin
            n_fail++; $display("FAIL rs_beat1: got v=%0b a=%0h want 1 8", bus.wr_valid, bus.wr_addr); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid: got %0b want 0", bus.wr_valid); end
        n_checks++; if (bus.status !== 3'b000) begin n_fail++; $display("FAIL rs_status: got %03b want 000", bus.status); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy: got %0b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus.wr_valid !== 1'b0 || bus.status !== 3'b000) begin
                n_fail++; $display("FAIL rs_after_%0d: got v=%0b st=%03b want 0 000", i, bus.wr_valid, bus.status); end
        end
    endtask

    task automatic test_random();
        pkt_t        pq [$];
        pkt_t        p;
        pkt_t        hd;
        logic [2:0]  m_status;
        logic [3:0]  m_addr;
        logic [19:0] m_data;
        logic        exp_valid;
        logic [3:0]  exp_addr;
        logic [19:0] exp_data;
        int          beat;
        bit          push_ok;
        do_reset();
        m_status = 3'b000;
        m_addr   = 4'd0;
        m_data   = 20'd0;
        beat     = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            exp_valid = 1'b0;
            exp_addr  = m_addr;
            exp_data  = m_data;
            if (pq.size() != 0) begin
                hd = pq[0];
                if (hd.op == OP_WRITE || hd.op == OP_SWAP) begin
                    exp_valid = 1'b1;
                    exp_addr  = (beat == 1) ? hd.db : hd.da;
                    exp_data  = visible_data(hd.mode, (beat == 1) ? hd.rb : hd.ra);
                end
            end
            n_checks++; if (bus.wr_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", cyc, bus.wr_valid, exp_valid); end
            n_checks++; if (bus.wr_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %0h want %0h", cyc, bus.wr_addr, exp_addr); end
            n_checks++; if (bus.wr_data !== exp_data) begin n_fail++; $display("FAIL rnd_data@%0d: got %0h want %0h", cyc, bus.wr_data, exp_data); end
            n_checks++; if (bus.in_ready !== (pq.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %0b want %0b", cyc, bus.in_ready, pq.size() < 2); end
            n_checks++; if (bus.busy !== (pq.size() != 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %0b want %0b", cyc, bus.busy, pq.size() != 0); end
            n_checks++; if (bus.status !== m_status) begin n_fail++; $display("FAIL rnd_status@%0d: got %03b want %03b", cyc, bus.status, m_status); end

            // Inputs for the coming edge; payload changes even when not valid.
            p = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   4'($urandom), 4'($urandom), 20'($urandom), 20'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
            if (cyc < 650) begin
                bus.wr_ready = ($urandom_range(0, 3) != 0);
                drive_pkt($urandom_range(0, 2) != 0, p);
            end else begin
                bus.wr_ready = 1'b1;
                drive_pkt(1'b0, p);
            end

            // Model the effect of the coming edge.
            push_ok = bus.in_valid && (pq.size() < 2);
            if (pq.size() != 0) begin
                if (!exp_valid) begin
                    m_status = apply_op(m_status, hd);
                    void'(pq.pop_front());
                end else if (bus.wr_ready) begin
                    m_addr = exp_addr;
                    m_data = exp_data;
                    if (hd.op == OP_SWAP && beat == 0) begin
                        beat = 1;
                    end else begin
                        m_status = apply_op(m_status, hd);
                        void'(pq.pop_front());
                        beat = 0;
                    end
                end
            end
            if (push_ok) pq.push_back(p);
            @(negedge clk);
        end
        n_checks++; if (bus.busy !== 1'b0 || bus.wr_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain: got busy=%0b v=%0b want 0 0", bus.busy, bus.wr_valid); end
        n_checks++; if (bus.status !== m_status) begin n_fail++; $display("FAIL rnd_final_status: got %03b want %03b", bus.status, m_status); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_write_full();
        test_write_half();
        test_swap();
        test_status_ops();
        test_backpressure();
        test_reset_mid_swap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
